// File: rtl/ex_mem_pkg.sv
// Shared constants and types for the EX/MEM pipeline register.
// Holds the core-wide widths, ALU op codes and the stage update decoder.
package ex_mem_pkg;

    localparam int DATA_W    = 32;
    localparam int REGADDR_W = 5;
    localparam int ALUOP_W   = 8;
    localparam int CNT_W     = 2;
    localparam int STALL_W   = 6;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic [DATA_W-1:0]    ZEROWORD       = '0;
    localparam logic [REGADDR_W-1:0] NOPREGADDR     = '0;
    localparam logic                 WRITEDISABLE   = 1'b0;
    localparam logic                 NOTINDELAYSLOT = 1'b0;
    localparam logic                 STOP           = 1'b1;
    localparam logic                 NOSTOP         = 1'b0;

    typedef enum logic [ALUOP_W-1:0] {
        EXE_NOP_OP   = 8'h00,
        EXE_AND_OP   = 8'h24,
        EXE_OR_OP    = 8'h25,
        EXE_ADD_OP   = 8'h20,
        EXE_MADD_OP  = 8'hA6,
        EXE_MADDU_OP = 8'hA8,
        EXE_MSUB_OP  = 8'hAA,
        EXE_MSUBU_OP = 8'hAB,
        EXE_LB_OP    = 8'hE0,
        EXE_LW_OP    = 8'hE3,
        EXE_SB_OP    = 8'hE8,
        EXE_SW_OP    = 8'hEB
    } aluop_e;

    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_BUBBLE,
        UPD_ADVANCE,
        UPD_HOLD
    } upd_e;

    // Flush beats every stall; an EX stall with MEM running drains MEM with a bubble.
    function automatic upd_e decode_update(input logic [STALL_W-1:0] stall,
                                           input logic               flush);
        if (flush) begin
            return UPD_FLUSH;
        end
        if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NOSTOP) begin
            return UPD_BUBBLE;
        end
        if (stall[STALL_EX] == NOSTOP) begin
            return UPD_ADVANCE;
        end
        return UPD_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX-to-MEM pipeline bus, plus the accumulate bookkeeping returned to EX.
// The slave modport is the pipeline register; master is the EX/MEM side.
interface ex_mem_if #(
    parameter int DATA_W    = ex_mem_pkg::DATA_W,
    parameter int REGADDR_W = ex_mem_pkg::REGADDR_W,
    parameter int ALUOP_W   = ex_mem_pkg::ALUOP_W,
    parameter int CNT_W     = ex_mem_pkg::CNT_W
);

    logic [REGADDR_W-1:0] ex_wd;
    logic                 ex_wreg;
    logic [DATA_W-1:0]    ex_wdata;
    logic                 ex_whilo;
    logic [DATA_W-1:0]    ex_hi;
    logic [DATA_W-1:0]    ex_lo;
    logic [ALUOP_W-1:0]   ex_aluop;
    logic [DATA_W-1:0]    ex_mem_addr;
    logic [DATA_W-1:0]    ex_reg2;
    logic                 ex_is_in_delayslot;
    logic [DATA_W-1:0]    ex_inst_addr;
    logic [2*DATA_W-1:0]  hilo_i;
    logic [CNT_W-1:0]     cnt_i;

    logic [REGADDR_W-1:0] mem_wd;
    logic                 mem_wreg;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_whilo;
    logic [DATA_W-1:0]    mem_hi;
    logic [DATA_W-1:0]    mem_lo;
    logic [ALUOP_W-1:0]   mem_aluop;
    logic [DATA_W-1:0]    mem_mem_addr;
    logic [DATA_W-1:0]    mem_reg2;
    logic                 mem_is_in_delayslot;
    logic [DATA_W-1:0]    mem_inst_addr;
    logic [2*DATA_W-1:0]  hilo_o;
    logic [CNT_W-1:0]     cnt_o;

    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
               ex_mem_addr, ex_reg2, ex_is_in_delayslot, ex_inst_addr,
               hilo_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
               mem_mem_addr, mem_reg2, mem_is_in_delayslot, mem_inst_addr,
               hilo_o, cnt_o
    );

    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
               ex_mem_addr, ex_reg2, ex_is_in_delayslot, ex_inst_addr,
               hilo_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
               mem_mem_addr, mem_reg2, mem_is_in_delayslot, mem_inst_addr,
               hilo_o, cnt_o
    );

endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures EX results for MEM, applies stall/flush,
// and parks the first MADD/MSUB step so a two-cycle accumulate survives its stall.
module ex_mem #(
    parameter int DATA_W    = ex_mem_pkg::DATA_W,
    parameter int REGADDR_W = ex_mem_pkg::REGADDR_W,
    parameter int ALUOP_W   = ex_mem_pkg::ALUOP_W,
    parameter int CNT_W     = ex_mem_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] stall,
    input  logic       flush,
    ex_mem_if.slave    bus
);

    import ex_mem_pkg::*;

    typedef struct packed {
        logic [REGADDR_W-1:0] wd;
        logic                 wreg;
        logic [DATA_W-1:0]    wdata;
        logic                 whilo;
        logic [DATA_W-1:0]    hi;
        logic [DATA_W-1:0]    lo;
        logic [ALUOP_W-1:0]   aluop;
        logic [DATA_W-1:0]    mem_addr;
        logic [DATA_W-1:0]    reg2;
        logic                 is_in_delayslot;
        logic [DATA_W-1:0]    inst_addr;
    } stage_t;

    // A bubble never writes GPRs or HI/LO and decodes as a NOP in MEM.
    function automatic stage_t bubble();
        stage_t b;
        b                 = '0;
        b.wd              = REGADDR_W'(NOPREGADDR);
        b.wreg            = WRITEDISABLE;
        b.wdata           = DATA_W'(ZEROWORD);
        b.whilo           = WRITEDISABLE;
        b.hi              = DATA_W'(ZEROWORD);
        b.lo              = DATA_W'(ZEROWORD);
        b.aluop           = ALUOP_W'(EXE_NOP_OP);
        b.mem_addr        = DATA_W'(ZEROWORD);
        b.reg2            = DATA_W'(ZEROWORD);
        b.is_in_delayslot = NOTINDELAYSLOT;
        b.inst_addr       = DATA_W'(ZEROWORD);
        return b;
    endfunction

    stage_t              stage_d, stage_q;
    stage_t              ex_stage;
    logic [2*DATA_W-1:0] hilo_d, hilo_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    upd_e                upd;

    always_comb begin
        ex_stage.wd              = bus.ex_wd;
        ex_stage.wreg            = bus.ex_wreg;
        ex_stage.wdata           = bus.ex_wdata;
        ex_stage.whilo           = bus.ex_whilo;
        ex_stage.hi              = bus.ex_hi;
        ex_stage.lo              = bus.ex_lo;
        ex_stage.aluop           = bus.ex_aluop;
        ex_stage.mem_addr        = bus.ex_mem_addr;
        ex_stage.reg2            = bus.ex_reg2;
        ex_stage.is_in_delayslot = bus.ex_is_in_delayslot;
        ex_stage.inst_addr       = bus.ex_inst_addr;
    end

    assign upd = decode_update(stall, flush);

    // NOTE: defaults first (hold) so every path assigns every output and no latch is inferred.
    always_comb begin
        stage_d = stage_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        unique case (upd)
            UPD_FLUSH: begin
                stage_d = bubble();
                hilo_d  = '0;
                cnt_d   = '0;
            end
            UPD_BUBBLE: begin
                stage_d = bubble();
                hilo_d  = bus.hilo_i;
                cnt_d   = bus.cnt_i;
            end
            UPD_ADVANCE: begin
                stage_d = ex_stage;
                hilo_d  = '0;
                cnt_d   = '0;
            end
            UPD_HOLD: begin
                stage_d = stage_q;
            end
            default: begin
                stage_d = stage_q;
            end
        endcase
    end

    // NOTE: non-blocking assignments for state so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= bubble();
            hilo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_wd              = stage_q.wd;
    assign bus.mem_wreg            = stage_q.wreg;
    assign bus.mem_wdata           = stage_q.wdata;
    assign bus.mem_whilo           = stage_q.whilo;
    assign bus.mem_hi              = stage_q.hi;
    assign bus.mem_lo              = stage_q.lo;
    assign bus.mem_aluop           = stage_q.aluop;
    assign bus.mem_mem_addr        = stage_q.mem_addr;
    assign bus.mem_reg2            = stage_q.reg2;
    assign bus.mem_is_in_delayslot = stage_q.is_in_delayslot;
    assign bus.mem_inst_addr       = stage_q.inst_addr;
    assign bus.hilo_o              = hilo_q;
    assign bus.cnt_o               = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: a driver pushes model-predicted outputs per edge,
// and a monitor pops and compares them one time step after each rising edge.
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic        dslot;
        logic [31:0] inst_addr;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } obs_t;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic        dslot;
        logic [31:0] inst_addr;
        logic [63:0] hilo_i;
        logic [1:0]  cnt_i;
    } stim_t;

    typedef struct {
        obs_t  exp;
        string name;
    } sb_item_t;

    logic       clk;
    logic       rst;
    logic [5:0] stall;
    logic       flush;

    ex_mem_if #(.DATA_W(32), .REGADDR_W(5), .ALUOP_W(8), .CNT_W(2)) bus ();

    ex_mem #(.DATA_W(32), .REGADDR_W(5), .ALUOP_W(8), .CNT_W(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_pass   = 0;
    obs_t     model    = '0;
    sb_item_t sb_q[$];

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.wd        = bus.mem_wd;
        o.wreg      = bus.mem_wreg;
        o.wdata     = bus.mem_wdata;
        o.whilo     = bus.mem_whilo;
        o.hi        = bus.mem_hi;
        o.lo        = bus.mem_lo;
        o.aluop     = bus.mem_aluop;
        o.mem_addr  = bus.mem_mem_addr;
        o.reg2      = bus.mem_reg2;
        o.dslot     = bus.mem_is_in_delayslot;
        o.inst_addr = bus.mem_inst_addr;
        o.hilo      = bus.hilo_o;
        o.cnt       = bus.cnt_o;
        return o;
    endfunction

    // Reference behaviour: what MEM and EX should see after one rising edge.
    function automatic obs_t predict(input obs_t cur, input stim_t s);
        obs_t n;
        n = cur;
        if (s.flush) begin
            n = '0;
        end else if (s.stall[3] && !s.stall[4]) begin
            n      = '0;
            n.hilo = s.hilo_i;
            n.cnt  = s.cnt_i;
        end else if (!s.stall[3]) begin
            n.wd        = s.wd;
            n.wreg      = s.wreg;
            n.wdata     = s.wdata;
            n.whilo     = s.whilo;
            n.hi        = s.hi;
            n.lo        = s.lo;
            n.aluop     = s.aluop;
            n.mem_addr  = s.mem_addr;
            n.reg2      = s.reg2;
            n.dslot     = s.dslot;
            n.inst_addr = s.inst_addr;
            n.hilo      = '0;
            n.cnt       = '0;
        end
        return n;
    endfunction

    task automatic drive_inputs(input stim_t s);
        stall                  = s.stall;
        flush                  = s.flush;
        bus.ex_wd              = s.wd;
        bus.ex_wreg            = s.wreg;
        bus.ex_wdata           = s.wdata;
        bus.ex_whilo           = s.whilo;
        bus.ex_hi              = s.hi;
        bus.ex_lo              = s.lo;
        bus.ex_aluop           = s.aluop;
        bus.ex_mem_addr        = s.mem_addr;
        bus.ex_reg2            = s.reg2;
        bus.ex_is_in_delayslot = s.dslot;
        bus.ex_inst_addr       = s.inst_addr;
        bus.hilo_i             = s.hilo_i;
        bus.cnt_i              = s.cnt_i;
    endtask

    // One edge of stimulus: drive at the falling edge, queue the predicted result.
    task automatic apply(input stim_t s, input string name);
        sb_item_t it;
        @(negedge clk);
        drive_inputs(s);
        model    = predict(model, s);
        it.exp   = model;
        it.name  = name;
        sb_q.push_back(it);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        int    mode;
        s.wd        = 5'($urandom);
        s.wreg      = 1'($urandom);
        s.wdata     = $urandom;
        s.whilo     = 1'($urandom);
        s.hi        = $urandom;
        s.lo        = $urandom;
        s.aluop     = 8'($urandom);
        s.mem_addr  = $urandom;
        s.reg2      = $urandom;
        s.dslot     = 1'($urandom);
        s.inst_addr = $urandom;
        s.hilo_i    = {$urandom, $urandom};
        s.cnt_i     = 2'($urandom);
        s.stall     = 6'($urandom);
        mode        = int'($urandom_range(0, 3));
        case (mode)
            0, 3:    s.stall[3] = 1'b0;
            1:       s.stall[4:3] = 2'b01;
            default: s.stall[4:3] = 2'b11;
        endcase
        s.flush = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    initial begin : monitor
        sb_item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                check(it.name, sample(), it.exp);
            end
        end
    end

    initial begin : driver
        stim_t s;
        rst = 1'b0;
        s   = '0;
        drive_inputs(s);

        #2;
        check("reset_initial", sample(), obs_t'(0));
        @(posedge clk);
        #2 rst = 1'b1;

        s = rand_stim();
        s.stall = 6'b000000;
        s.flush = 1'b0;
        apply(s, "prime_before_reset");

        // Asynchronous reset mid-cycle must clear outputs before any edge.
        @(posedge clk);
        #2;
        s = '0;
        s.wreg  = 1'b1;
        s.wdata = 32'hDEADBEEF;
        drive_inputs(s);
        rst = 1'b0;
        #1;
        model = '0;
        check("reset_async", sample(), obs_t'(0));
        #1 rst = 1'b1;
        apply(s, "reset_release");

        s = '0;
        s.wd = 5'd5; s.wdata = 32'h12345678; s.whilo = 1'b1; s.hi = 32'h1; s.lo = 32'h2;
        apply(s, "pass_through");

        s = rand_stim();
        s.stall = 6'b001111; s.flush = 1'b0; s.wreg = 1'b1;
        s.hilo_i = 64'h0000_0001_0000_0002; s.cnt_i = 2'd1; s.aluop = 8'hA6;
        apply(s, "ex_stall");
        s.stall = 6'b000000; s.cnt_i = 2'd2;
        apply(s, "accum_release");

        s = '0;
        s.wdata = 32'hAA;
        apply(s, "hold_setup");
        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.stall = 6'b011111; s.flush = 1'b0;
            apply(s, "full_hold");
        end

        s = rand_stim();
        s.stall = 6'b001111; s.flush = 1'b0; s.cnt_i = 2'd1;
        apply(s, "flush_setup");
        s = rand_stim();
        s.stall = 6'b001111; s.flush = 1'b1; s.wreg = 1'b1; s.cnt_i = 2'd1;
        apply(s, "flush_over_stall");

        s = '0;
        s.dslot = 1'b1; s.inst_addr = 32'hBFC00004;
        apply(s, "dslot_pc");

        for (int i = 0; i < 300; i++) begin
            apply(rand_stim(), "random");
        end

        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
